// File: rtl/ucode_sequencer_if.sv
// Fetch / microcode ROM / issue signal bundle for ucode_sequencer.
// The master modport is the sequencer's view; the slave modport is the
// surrounding pipeline (fetch, ROM, decode, execute).
interface ucode_sequencer_if;
  logic [31:0] fetch_instr;
  logic        fetch_valid;
  logic        fetch_stall;
  logic [6:0]  mul_opcode;
  logic [15:0] immediate;
  logic [3:0]  dest_reg;
  logic [3:0]  reg1;
  logic [3:0]  reg2;
  logic [3:0]  ghost_pc;
  logic [31:0] ucode_instr;
  logic [31:0] issue_instr;
  logic        issue_valid;
  logic        issue_ready;
  logic        ubr_resolve;
  logic        ubr_taken;
  logic        busy;

  modport master (
    input  fetch_instr, fetch_valid, ucode_instr, issue_ready, ubr_resolve, ubr_taken,
    output fetch_stall, mul_opcode, immediate, dest_reg, reg1, reg2, ghost_pc,
           issue_instr, issue_valid, busy
  );

  modport slave (
    output fetch_instr, fetch_valid, ucode_instr, issue_ready, ubr_resolve, ubr_taken,
    input  fetch_stall, mul_opcode, immediate, dest_reg, reg1, reg2, ghost_pc,
           issue_instr, issue_valid, busy
  );
endinterface

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: passes normal instructions from fetch to issue,
// expands multiplies into a ROM-resident micro-op sequence, resolves
// micro-branches and hands control back to fetch on a halt micro-op.
module ucode_sequencer #(
  parameter logic [3:0] HALT_OP = 4'b1101,
  parameter logic [6:0] UBR_OP  = 7'b1100001
) (
  input logic               clk,
  input logic               rst,
  ucode_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT_BR = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  ghost_pc_q, ghost_pc_d;
  logic [6:0]  opcode_q, opcode_d;
  logic [15:0] imm_q, imm_d;
  logic [3:0]  dest_q, dest_d;
  logic [3:0]  reg1_q, reg1_d;
  logic [3:0]  reg2_q, reg2_d;

  logic [31:0] issue_instr;
  logic        issue_valid;
  logic        fetch_stall;
  logic        fetch_is_mul;
  logic        uop_is_halt;
  logic        uop_is_branch;

  function automatic logic is_mul_op(input logic [6:0] op);
    logic hit;
    case (op)
      7'b0010000, 7'b0011000, 7'b0110000, 7'b0111000: hit = 1'b1;
      default:                                         hit = 1'b0;
    endcase
    return hit;
  endfunction

  assign fetch_is_mul  = bus.fetch_valid & is_mul_op(bus.fetch_instr[31:25]);
  assign uop_is_halt   = (bus.ucode_instr[31:28] == HALT_OP);
  assign uop_is_branch = (bus.ucode_instr[31:25] == UBR_OP);

  // State register, ROM address and latched multiply fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ghost_pc_q <= 4'd0;
      opcode_q   <= 7'd0;
      imm_q      <= 16'd0;
      dest_q     <= 4'd0;
      reg1_q     <= 4'd0;
      reg2_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      ghost_pc_q <= ghost_pc_d;
      opcode_q   <= opcode_d;
      imm_q      <= imm_d;
      dest_q     <= dest_d;
      reg1_q     <= reg1_d;
      reg2_q     <= reg2_d;
    end
  end

  // Next-state, ghost_pc stepping and issue/stall outputs per state.
  always_comb begin
    state_d     = state_q;
    ghost_pc_d  = ghost_pc_q;
    opcode_d    = opcode_q;
    imm_d       = imm_q;
    dest_d      = dest_q;
    reg1_d      = reg1_q;
    reg2_d      = reg2_q;
    issue_instr = 32'h0000_0000;
    issue_valid = 1'b0;
    fetch_stall = 1'b1;

    case (state_q)
      S_IDLE: begin
        issue_instr = bus.fetch_instr;
        if (fetch_is_mul) begin
          // The multiply itself is swallowed; its fields drive the ROM.
          issue_valid = 1'b0;
          fetch_stall = 1'b1;
          opcode_d    = bus.fetch_instr[31:25];
          imm_d       = bus.fetch_instr[15:0];
          dest_d      = bus.fetch_instr[24:21];
          reg1_d      = bus.fetch_instr[20:17];
          reg2_d      = bus.fetch_instr[16:13];
          ghost_pc_d  = 4'd0;
          state_d     = S_LOAD;
        end else begin
          // Gate with reset so nothing is issued while reset is asserted.
          issue_valid = bus.fetch_valid & rst;
          fetch_stall = bus.fetch_valid & ~bus.issue_ready;
        end
      end

      S_LOAD: begin
        // ROM registers rom[ghost_pc] during this cycle.
        state_d = S_ISSUE;
      end

      S_ISSUE: begin
        if (uop_is_halt) begin
          state_d = S_DONE;
        end else begin
          issue_instr = bus.ucode_instr;
          issue_valid = 1'b1;
          if (bus.issue_ready) begin
            if (uop_is_branch) begin
              state_d = S_WAIT_BR;
            end else begin
              ghost_pc_d = ghost_pc_q + 4'd1;
              state_d    = S_LOAD;
            end
          end else begin
            state_d = S_ISSUE;
          end
        end
      end

      S_WAIT_BR: begin
        // ghost_pc is frozen here, so ucode_instr still holds the branch.
        if (bus.ubr_resolve) begin
          if (bus.ubr_taken) begin
            ghost_pc_d = ghost_pc_q + bus.ucode_instr[3:0];
          end else begin
            ghost_pc_d = ghost_pc_q + 4'd1;
          end
          state_d = S_LOAD;
        end else begin
          state_d = S_WAIT_BR;
        end
      end

      S_DONE: begin
        // Releasing the stall lets fetch step past the multiply.
        fetch_stall = 1'b0;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.issue_instr = issue_instr;
  assign bus.issue_valid = issue_valid;
  assign bus.fetch_stall = fetch_stall;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.ghost_pc    = ghost_pc_q;
  assign bus.mul_opcode  = opcode_q;
  assign bus.immediate   = imm_q;
  assign bus.dest_reg    = dest_q;
  assign bus.reg1        = reg1_q;
  assign bus.reg2        = reg2_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed testbench for ucode_sequencer with a behavioural registered ROM.
`timescale 1ns/1ps
module tb_ucode_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ucode_sequencer_if bus();

  ucode_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [31:0] HALT = 32'hD000_0000;
  localparam logic [31:0] BR   = 32'hC200_0000;
  localparam logic [31:0] UOP  = 32'h0A00_0000;

  logic [31:0] rom [16];

  // Registered ROM: ucode_instr is rom[ghost_pc] from the previous cycle.
  always @(posedge clk) bus.ucode_instr <= rom[bus.ghost_pc];

  int n_checks = 0;
  int n_pass   = 0;
  int issued_q[$];
  bit br_q[$];
  int done_cnt, busy_cyc, first_issue_cyc, hold_bad;

  function automatic logic [63:0] pack_q();
    logic [63:0] s;
    s = 64'h0;
    foreach (issued_q[i]) s = {s[59:0], issued_q[i][3:0]};
    return s;
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = HALT;
  endtask

  // Runs one microcode sequence from IDLE (multiply presented) to after DONE.
  task automatic run_seq(input int stall_pc, input int stall_len,
                         input logic [31:0] next_instr, input logic next_valid,
                         output bit timed_out);
    int stall_left;
    bit wbr, stalling, done;
    logic [31:0] held_instr;
    logic [3:0]  held_pc;
    stall_left = stall_len;
    wbr = 1'b0; stalling = 1'b0; done = 1'b0;
    held_instr = 32'h0; held_pc = 4'h0;
    issued_q.delete();
    done_cnt = 0; busy_cyc = 0; first_issue_cyc = -1; hold_bad = 0;
    timed_out = 1'b1;
    for (int c = 0; c < 200; c++) begin
      bus.ubr_resolve = 1'b0;
      bus.ubr_taken   = 1'b0;
      bus.issue_ready = 1'b1;
      if (wbr) begin
        bus.ubr_resolve = 1'b1;
        bus.ubr_taken   = (br_q.size() > 0) ? br_q.pop_front() : 1'b0;
        wbr = 1'b0;
      end
      #1;
      if (bus.busy && bus.issue_valid && bus.ghost_pc == stall_pc[3:0] && stall_left > 0) begin
        if (!stalling) begin
          held_instr = bus.issue_instr;
          held_pc    = bus.ghost_pc;
          stalling   = 1'b1;
        end else if (bus.issue_instr !== held_instr || bus.ghost_pc !== held_pc) begin
          hold_bad++;
        end
        bus.issue_ready = 1'b0;
        stall_left--;
        #1;
      end
      if (bus.busy) busy_cyc++;
      if (bus.busy && bus.issue_valid && bus.issue_ready) begin
        issued_q.push_back(int'(bus.ghost_pc));
        if (first_issue_cyc < 0) first_issue_cyc = c;
        if (bus.issue_instr[31:25] == 7'b1100001) wbr = 1'b1;
      end
      if (bus.busy && !bus.fetch_stall) begin
        done_cnt++;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (done) begin
        bus.fetch_instr = next_instr;
        bus.fetch_valid = next_valid;
      end
      @(negedge clk);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
    bus.ubr_resolve = 1'b0;
    bus.issue_ready = 1'b1;
  endtask

  task automatic test_reset();
    bus.fetch_instr = 32'h0; bus.fetch_valid = 1'b0;
    bus.issue_ready = 1'b1;  bus.ubr_resolve = 1'b0; bus.ubr_taken = 1'b0;
    clear_rom();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", bus.busy); else n_pass++;
    n_checks++; if (bus.issue_valid !== 1'b0) $display("FAIL reset_issue_valid: got %0b expected 0", bus.issue_valid); else n_pass++;
    n_checks++; if (bus.ghost_pc !== 4'd0) $display("FAIL reset_ghost_pc: got %0d expected 0", bus.ghost_pc); else n_pass++;
    n_checks++;
    if ({bus.mul_opcode, bus.immediate, bus.dest_reg, bus.reg1, bus.reg2} !== 39'd0)
      $display("FAIL reset_fields: got %0h expected 0", {bus.mul_opcode, bus.immediate, bus.dest_reg, bus.reg1, bus.reg2});
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_passthrough();
    bus.fetch_instr = 32'h6200_0000; bus.fetch_valid = 1'b1; bus.issue_ready = 1'b1;
    #1;
    n_checks++; if (bus.issue_instr !== 32'h6200_0000) $display("FAIL pt_instr: got %0h expected 62000000", bus.issue_instr); else n_pass++;
    n_checks++; if (bus.issue_valid !== 1'b1) $display("FAIL pt_valid: got %0b expected 1", bus.issue_valid); else n_pass++;
    n_checks++; if (bus.fetch_stall !== 1'b0) $display("FAIL pt_stall: got %0b expected 0", bus.fetch_stall); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL pt_busy: got %0b expected 0", bus.busy); else n_pass++;
    bus.issue_ready = 1'b0;
    #1;
    n_checks++; if (bus.fetch_stall !== 1'b1) $display("FAIL pt_backpressure: got %0b expected 1", bus.fetch_stall); else n_pass++;
    // Opcode one bit off a multiply must pass straight through.
    bus.fetch_instr = 32'h2200_0000; bus.issue_ready = 1'b1;
    #1;
    n_checks++; if (bus.issue_valid !== 1'b1) $display("FAIL pt_near_mul: got %0b expected 1", bus.issue_valid); else n_pass++;
    bus.fetch_valid = 1'b0;
    #1;
    n_checks++; if (bus.issue_valid !== 1'b0) $display("FAIL pt_invalid: got %0b expected 0", bus.issue_valid); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_multiply();
    bit to;
    clear_rom();
    for (int i = 0; i < 4; i++) rom[i] = UOP | i;
    rom[4] = BR | 32'h0000_FFFD;   // -3: back to ghost_pc 1
    rom[5] = HALT;
    br_q = '{1'b1, 1'b0};
    bus.fetch_instr = 32'h306A_0002; bus.fetch_valid = 1'b1; bus.issue_ready = 1'b1;
    #1;
    n_checks++; if (bus.issue_valid !== 1'b0) $display("FAIL mul_not_issued: got %0b expected 0", bus.issue_valid); else n_pass++;
    n_checks++; if (bus.fetch_stall !== 1'b1) $display("FAIL mul_detect_stall: got %0b expected 1", bus.fetch_stall); else n_pass++;
    run_seq(-1, 0, 32'h0, 1'b0, to);
    n_checks++; if (to) $display("FAIL mul_timeout: got timeout expected DONE"); else n_pass++;
    n_checks++;
    if (issued_q.size() != 9 || pack_q() !== 64'h0_1234_1234)
      $display("FAIL mul_order: got %0h (n=%0d) expected 12341234 (n=9)", pack_q(), issued_q.size());
    else n_pass++;
    n_checks++; if (done_cnt != 1) $display("FAIL mul_done_once: got %0d expected 1", done_cnt); else n_pass++;
    n_checks++; if (first_issue_cyc != 2) $display("FAIL mul_first_latency: got %0d expected 2", first_issue_cyc); else n_pass++;
    n_checks++; if (busy_cyc != 23) $display("FAIL mul_cycles: got %0d expected 23", busy_cyc); else n_pass++;
    n_checks++;
    if ({bus.mul_opcode, bus.immediate, bus.dest_reg, bus.reg1, bus.reg2} !== {7'b0011000, 16'h0002, 4'd3, 4'd5, 4'd0})
      $display("FAIL mul_fields: got %0h expected %0h", {bus.mul_opcode, bus.immediate, bus.dest_reg, bus.reg1, bus.reg2},
               {7'b0011000, 16'h0002, 4'd3, 4'd5, 4'd0});
    else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL mul_back_idle: got %0b expected 0", bus.busy); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit to;
    clear_rom();
    for (int i = 0; i < 4; i++) rom[i] = UOP | i;
    rom[4] = HALT;
    br_q.delete();
    bus.fetch_instr = 32'h2000_0000; bus.fetch_valid = 1'b1;
    run_seq(2, 3, 32'h0, 1'b0, to);
    n_checks++; if (to) $display("FAIL bp_timeout: got timeout expected DONE"); else n_pass++;
    n_checks++;
    if (issued_q.size() != 4 || pack_q() !== 64'h0123)
      $display("FAIL bp_order: got %0h (n=%0d) expected 123 (n=4)", pack_q(), issued_q.size());
    else n_pass++;
    n_checks++; if (hold_bad != 0) $display("FAIL bp_hold: got %0d changes expected 0", hold_bad); else n_pass++;
    n_checks++; if (busy_cyc != 14) $display("FAIL bp_cycles: got %0d expected 14", busy_cyc); else n_pass++;
  endtask

  task automatic test_wrap();
    bit to;
    clear_rom();
    rom[0]  = BR | 32'h0000_000E;  // 0 + 14 = 14
    rom[14] = BR | 32'h0000_0003;  // 14 + 3 wraps to 1
    rom[1]  = BR | 32'h0000_000E;  // 1 + 14 = 15
    rom[15] = UOP | 32'd15;        // 15 + 1 wraps to 0
    rom[2]  = HALT;
    br_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bus.fetch_instr = 32'h6000_0000; bus.fetch_valid = 1'b1;
    run_seq(-1, 0, 32'h0, 1'b0, to);
    n_checks++; if (to) $display("FAIL wrap_timeout: got timeout expected DONE"); else n_pass++;
    n_checks++;
    if (issued_q.size() != 6 || pack_q() !== 64'h0E1F01)
      $display("FAIL wrap_order: got %0h (n=%0d) expected e1f01 (n=6)", pack_q(), issued_q.size());
    else n_pass++;
    n_checks++; if (busy_cyc != 20) $display("FAIL wrap_cycles: got %0d expected 20", busy_cyc); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit to;
    clear_rom();
    rom[0] = UOP;
    rom[1] = BR | 32'h0000_0001;
    rom[2] = HALT;
    bus.fetch_instr = 32'h306A_0002; bus.fetch_valid = 1'b1;
    bus.issue_ready = 1'b1; bus.ubr_resolve = 1'b0;
    repeat (5) @(negedge clk);    // IDLE, LOAD, ISSUE 0, LOAD, ISSUE 1 -> WAIT_BR
    #1;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.ghost_pc !== 4'd1 || bus.issue_valid !== 1'b0)
      $display("FAIL rstmid_in_wait: got busy=%0b pc=%0d valid=%0b expected 1 1 0", bus.busy, bus.ghost_pc, bus.issue_valid);
    else n_pass++;
    #1;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %0b expected 0", bus.busy); else n_pass++;
    n_checks++; if (bus.issue_valid !== 1'b0) $display("FAIL rstmid_valid: got %0b expected 0", bus.issue_valid); else n_pass++;
    n_checks++; if (bus.ghost_pc !== 4'd0) $display("FAIL rstmid_pc: got %0d expected 0", bus.ghost_pc); else n_pass++;
    n_checks++; if (bus.dest_reg !== 4'd0) $display("FAIL rstmid_dest: got %0d expected 0", bus.dest_reg); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    br_q = '{1'b1};
    run_seq(-1, 0, 32'h0, 1'b0, to);
    n_checks++; if (to) $display("FAIL rstmid_timeout: got timeout expected DONE"); else n_pass++;
    n_checks++;
    if (issued_q.size() != 2 || pack_q() !== 64'h01)
      $display("FAIL rstmid_restart: got %0h (n=%0d) expected 1 (n=2)", pack_q(), issued_q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit to;
    clear_rom();
    for (int i = 0; i < 3; i++) rom[i] = UOP | i;
    rom[3] = HALT;
    br_q.delete();
    bus.fetch_instr = 32'h6000_0005; bus.fetch_valid = 1'b1;
    run_seq(-1, 0, 32'h7125_E123, 1'b1, to);
    n_checks++; if (to) $display("FAIL b2b_timeout1: got timeout expected DONE"); else n_pass++;
    n_checks++; if (busy_cyc != 9) $display("FAIL b2b_cycles1: got %0d expected 9", busy_cyc); else n_pass++;
    n_checks++;
    if ({bus.mul_opcode, bus.immediate, bus.dest_reg, bus.reg1, bus.reg2} !== {7'b0110000, 16'h0005, 4'd0, 4'd0, 4'd0})
      $display("FAIL b2b_fields1: got %0h expected %0h", {bus.mul_opcode, bus.immediate, bus.dest_reg, bus.reg1, bus.reg2},
               {7'b0110000, 16'h0005, 4'd0, 4'd0, 4'd0});
    else n_pass++;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.issue_valid !== 1'b0 || bus.fetch_stall !== 1'b1)
      $display("FAIL b2b_detect: got busy=%0b valid=%0b stall=%0b expected 0 0 1", bus.busy, bus.issue_valid, bus.fetch_stall);
    else n_pass++;
    run_seq(-1, 0, 32'h0, 1'b0, to);
    n_checks++; if (to) $display("FAIL b2b_timeout2: got timeout expected DONE"); else n_pass++;
    n_checks++;
    if (issued_q.size() != 3 || pack_q() !== 64'h012)
      $display("FAIL b2b_order2: got %0h (n=%0d) expected 12 (n=3)", pack_q(), issued_q.size());
    else n_pass++;
    n_checks++;
    if ({bus.mul_opcode, bus.immediate, bus.dest_reg, bus.reg1, bus.reg2} !== {7'b0111000, 16'hE123, 4'd9, 4'd2, 4'd15})
      $display("FAIL b2b_fields2: got %0h expected %0h", {bus.mul_opcode, bus.immediate, bus.dest_reg, bus.reg1, bus.reg2},
               {7'b0111000, 16'hE123, 4'd9, 4'd2, 4'd15});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_multiply();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
